// File: rtl/divider_reconstructor.sv
// divider_reconstructor: rebuilds the dividend rin = q * div + rout with a
// shift-and-add loop over the quotient bits, behind a valid/ready handshake.
// Optional feature macro: DIVIDER_RECON_EARLY_EXIT_EN -- when defined, the run
// stops as soon as no quotient bits remain set, so latency follows the highest
// set bit of q instead of always taking N cycles. Results are identical.
//
// state | meaning
// IDLE  | waiting for operands, in_ready high
// RUN   | one quotient bit consumed per cycle
// DONE  | result presented on rin, held until out_ready
module divider_reconstructor #(
    parameter int N = 4,
    parameter int M = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [N-1:0]     q,
    input  logic [M-1:0]     div,
    input  logic [N-1:0]     rout,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [N+M-1:0]   rin,
    output logic             busy
);

    localparam int W  = N + M;
    localparam int CW = $clog2(N + 1);

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t          state, state_nx;
    logic [W-1:0]    acc, acc_nx;
    logic [W-1:0]    mcand, mcand_nx;
    logic [N-1:0]    mplier, mplier_nx;
    logic [CW-1:0]   cnt, cnt_nx;
    logic            skip;
    logic            last;

    // Early exit: an all-zero multiplier ends the run untouched, and a
    // multiplier with no bits left above bit 0 ends it after this step.
`ifdef DIVIDER_RECON_EARLY_EXIT_EN
    assign skip = (mplier == '0);
    assign last = (cnt == CW'(1)) || ((mplier >> 1) == '0);
`else
    assign skip = 1'b0;
    assign last = (cnt == CW'(1));
`endif

    // State and datapath registers; reset discards any operation in flight.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state  <= IDLE;
            acc    <= '0;
            mcand  <= '0;
            mplier <= '0;
            cnt    <= '0;
        end else begin
            state  <= state_nx;
            acc    <= acc_nx;
            mcand  <= mcand_nx;
            mplier <= mplier_nx;
            cnt    <= cnt_nx;
        end
    end

    // Next-state and datapath update: operands are captured only at accept.
    always_comb begin
        state_nx  = state;
        acc_nx    = acc;
        mcand_nx  = mcand;
        mplier_nx = mplier;
        cnt_nx    = cnt;
        case (state)
            IDLE: begin
                if (in_valid) begin
                    acc_nx    = {{M{1'b0}}, rout};
                    mcand_nx  = {{N{1'b0}}, div};
                    mplier_nx = q;
                    cnt_nx    = CW'(N);
                    state_nx  = RUN;
                end
            end
            RUN: begin
                if (skip) begin
                    state_nx = DONE;
                end else begin
                    if (mplier[0]) begin
                        acc_nx = acc + mcand;
                    end
                    mcand_nx  = mcand << 1;
                    mplier_nx = mplier >> 1;
                    cnt_nx    = cnt - CW'(1);
                    if (last) begin
                        state_nx = DONE;
                    end
                end
            end
            DONE: begin
                if (out_ready) begin
                    state_nx = IDLE;
                end
            end
            default: state_nx = IDLE;
        endcase
    end

    // Outputs decode from state and registers only.
    always_comb begin
        in_ready  = (state == IDLE);
        out_valid = (state == DONE);
        busy      = (state != IDLE);
        rin       = (state == DONE) ? acc : '0;
    end

endmodule

// File: tb/tb_divider_reconstructor.sv
// Directed bench for divider_reconstructor (N=4, M=4) with an expected-result
// queue filled at accept and drained when out_valid is observed.
module tb_divider_reconstructor;

    localparam int N = 4;
    localparam int M = 4;

    logic             clk = 1'b0;
    logic             rst_n;
    logic             in_valid;
    logic             in_ready;
    logic [N-1:0]     q;
    logic [M-1:0]     div;
    logic [N-1:0]     rout;
    logic             out_valid;
    logic             out_ready;
    logic [N+M-1:0]   rin;
    logic             busy;

    int pass_cnt  = 0;
    int total_cnt = 0;
    int exp_q[$];

    divider_reconstructor #(.N(N), .M(M)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .q         (q),
        .div       (div),
        .rout      (rout),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .rin       (rin),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total_cnt++;
        assert (obs === exp) pass_cnt++;
        else $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    endtask

    function automatic int exp_lat(input int qv);
`ifdef DIVIDER_RECON_EARLY_EXIT_EN
        int l;
        l = 1;
        for (int i = 0; i < N; i++) begin
            if (qv[i]) l = i + 1;
        end
        return l;
`else
        return N;
`endif
    endfunction

    // One operation: accept, scramble operands during RUN, measure latency,
    // compare result, optionally hold out_ready low for 10 cycles.
    task automatic do_op(input int qv, input int dv, input int rv, input bit bp);
        int lat;
        int exp_val;
        bit stable;
        @(negedge clk);
        check("in_ready_before_accept", 32'(in_ready), 32'd1);
        q         = qv[N-1:0];
        div       = dv[M-1:0];
        rout      = rv[N-1:0];
        in_valid  = 1'b1;
        out_ready = !bp;
        exp_q.push_back(qv * dv + rv);
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
        q    = N'($urandom_range(0, 15));
        div  = M'($urandom_range(0, 15));
        rout = N'($urandom_range(0, 15));
        check("busy_after_accept", 32'(busy), 32'd1);
        lat = 0;
        while (!out_valid && lat < 40) begin
            @(negedge clk);
            lat++;
        end
        check("latency", 32'(lat), 32'(exp_lat(qv)));
        if (!out_valid) begin
            check("out_valid_timeout", 32'd0, 32'd1);
            exp_q.delete();
            return;
        end
        exp_val = exp_q.pop_front();
        check("rin", 32'(rin), 32'(exp_val));
        check("in_ready_low_in_done", 32'(in_ready), 32'd0);
        if (bp) begin
            stable = 1'b1;
            repeat (10) begin
                @(negedge clk);
                if (!(out_valid === 1'b1 && rin === (N+M)'(exp_val))) stable = 1'b0;
            end
            check("backpressure_hold", 32'(stable), 32'd1);
            out_ready = 1'b1;
        end
        @(negedge clk);
        check("out_valid_one_cycle", 32'(out_valid), 32'd0);
        check("in_ready_after_handshake", 32'(in_ready), 32'd1);
        check("busy_after_handshake", 32'(busy), 32'd0);
    endtask

    initial begin
        rst_n     = 1'b0;
        in_valid  = 1'b0;
        out_ready = 1'b1;
        q         = '0;
        div       = '0;
        rout      = '0;
        repeat (2) @(negedge clk);
        check("reset_out_valid", 32'(out_valid), 32'd0);
        check("reset_busy", 32'(busy), 32'd0);
        check("reset_rin", 32'(rin), 32'd0);
        rst_n = 1'b1;
        @(negedge clk);
        check("reset_in_ready", 32'(in_ready), 32'd1);

        do_op(13, 11, 7, 1'b0);
        do_op(15, 15, 15, 1'b0);
        do_op(5, 3, 2, 1'b1);
        do_op(6, 7, 0, 1'b0);
        do_op(0, 9, 3, 1'b0);
        do_op(1, 0, 12, 1'b0);

        // Reset two cycles after accept: nothing may come out.
        @(negedge clk);
        q = 4'd5; div = 4'd5; rout = 4'd5; in_valid = 1'b1;
        exp_q.push_back(30);
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        check("midrun_reset_out_valid", 32'(out_valid), 32'd0);
        check("midrun_reset_busy", 32'(busy), 32'd0);
        check("midrun_reset_rin", 32'(rin), 32'd0);
        exp_q.delete();
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        check("midrun_reset_in_ready", 32'(in_ready), 32'd1);
        check("midrun_reset_no_valid", 32'(out_valid), 32'd0);
        do_op(2, 4, 1, 1'b0);

        for (int i = 0; i < 6; i++) begin
            do_op($urandom_range(0, 15), $urandom_range(0, 15), $urandom_range(0, 15), 1'b0);
        end

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
